// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start-bit detect, LSB-first word assembly, optional even parity,
// single-word output buffer with valid/ready handshake and overrun pulse.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle (0); a 1 is taken as the start bit
// S_DATA   | shifting WIDTH data bits into the accumulator, LSB first
// S_PARITY | sampling the trailing even-parity bit (PARITY_EN=1 only)
module serial_frame_receiver #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             serial_in,
  input  logic             ready,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             parity_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] acc;

  logic [WIDTH-1:0] acc_next;
  logic             last_data;
  logic             complete;
  logic [WIDTH-1:0] word;
  logic             word_err;
  logic             take;

  // New bits enter at the MSB so the first bit ends up in bit 0 after WIDTH shifts.
  assign acc_next  = {serial_in, acc[WIDTH-1:1]};
  assign last_data = (state == S_DATA) && (bit_cnt == CW'(WIDTH - 1));
  assign complete  = (state == S_PARITY) || (last_data && !PARITY_EN);
  assign word      = (state == S_PARITY) ? acc : acc_next;
  assign word_err  = PARITY_EN && (state == S_PARITY) && (serial_in ^ (^acc));
  assign take      = !valid || ready;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (!clear) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      acc     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          bit_cnt <= '0;
          if (serial_in) begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          acc     <= acc_next;
          bit_cnt <= bit_cnt + CW'(1);
          if (last_data) begin
            state <= PARITY_EN ? S_PARITY : S_IDLE;
          end
        end
        S_PARITY: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // A word consumed on the same edge a new one completes is replaced, not cleared.
  always_ff @(posedge clock) begin
    if (!clear) begin
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete && take) begin
        data_out   <= word;
        parity_err <= word_err;
        valid      <= 1'b1;
      end else if (complete) begin
        overrun <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: one parity build and one no-parity build, driven by
// directed frames then random line traffic, compared against a frame-level reference model.
module tb_serial_frame_receiver;

  logic       clock = 1'b0;
  logic       clear;
  logic       ready;
  logic       serial_p, serial_n;
  logic [7:0] data_p, data_n;
  logic       valid_p, valid_n, err_p, err_n, ovr_p, ovr_n, busy_p, busy_n;

  always #5 clock = ~clock;

  serial_frame_receiver #(.WIDTH(8), .PARITY_EN(1'b1)) u_par (
    .clock(clock), .clear(clear), .serial_in(serial_p), .ready(ready),
    .data_out(data_p), .valid(valid_p), .parity_err(err_p), .overrun(ovr_p), .busy(busy_p));

  serial_frame_receiver #(.WIDTH(8), .PARITY_EN(1'b0)) u_nop (
    .clock(clock), .clear(clear), .serial_in(serial_n), .ready(ready),
    .data_out(data_n), .valid(valid_n), .parity_err(err_n), .overrun(ovr_n), .busy(busy_n));

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frames are located in the recorded line history by index arithmetic.
  bit         hist [2][8192];
  int         e = 0;
  int         st [2] = '{-1, -1};
  bit         mv [2], me [2], mo [2];
  logic [7:0] md [2];
  bit         qp [$];
  bit         qn [$];

  task automatic model_edge(input int d, input bit b, input bit rdy, input bit clr);
    int   flen;
    bit   done;
    bit   perr;
    logic [7:0] w;
    flen = (d == 0) ? 10 : 9;
    mo[d] = 1'b0;
    if (!clr) begin
      st[d] = -1; mv[d] = 1'b0; me[d] = 1'b0; md[d] = 8'h00;
      return;
    end
    hist[d][e] = b;
    done = 1'b0;
    perr = 1'b0;
    w    = 8'h00;
    if (st[d] < 0) begin
      if (b) st[d] = e;
    end else if (e == st[d] + flen - 1) begin
      for (int i = 0; i < 8; i++) w[i] = hist[d][st[d] + 1 + i];
      if (d == 0) perr = hist[d][st[d] + 9] ^ (^w);
      done  = 1'b1;
      st[d] = -1;
    end
    if (done) begin
      if (!mv[d] || rdy) begin
        md[d] = w; me[d] = perr; mv[d] = 1'b1;
      end else begin
        mo[d] = 1'b1;
      end
    end else if (mv[d] && rdy) begin
      mv[d] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("p_valid", 32'(valid_p), 32'(mv[0]));
    chk("p_data",  32'(data_p),  32'(md[0]));
    chk("p_perr",  32'(err_p),   32'(me[0]));
    chk("p_ovr",   32'(ovr_p),   32'(mo[0]));
    chk("p_busy",  32'(busy_p),  32'(st[0] >= 0));
    chk("n_valid", 32'(valid_n), 32'(mv[1]));
    chk("n_data",  32'(data_n),  32'(md[1]));
    chk("n_perr",  32'(err_n),   32'(me[1]));
    chk("n_ovr",   32'(ovr_n),   32'(mo[1]));
    chk("n_busy",  32'(busy_n),  32'(st[1] >= 0));
  endtask

  task automatic tick(input bit rdy, input bit clr);
    bit bp, bn;
    bp = (qp.size() > 0) ? qp.pop_front() : 1'b0;
    bn = (qn.size() > 0) ? qn.pop_front() : 1'b0;
    serial_p = bp;
    serial_n = bn;
    ready    = rdy;
    clear    = clr;
    @(posedge clock);
    #1;
    model_edge(0, bp, rdy, clr);
    model_edge(1, bn, rdy, clr);
    e++;
    check_outputs();
  endtask

  task automatic frame_p(input logic [7:0] w, input bit par);
    qp.push_back(1'b1);
    for (int i = 0; i < 8; i++) qp.push_back(w[i]);
    qp.push_back(par);
  endtask

  task automatic frame_n(input logic [7:0] w);
    qn.push_back(1'b1);
    for (int i = 0; i < 8; i++) qn.push_back(w[i]);
  endtask

  initial begin
    serial_p = 1'b0; serial_n = 1'b0; ready = 1'b0; clear = 1'b0;
    repeat (3) tick(1'b0, 1'b0);
    chk("rst_valid", 32'(valid_p), 32'd0);
    chk("rst_busy",  32'(busy_p),  32'd0);
    repeat (2) tick(1'b1, 1'b1);

    // basic receive, ready held high
    frame_p(8'hA5, 1'b0);
    repeat (10) tick(1'b1, 1'b1);
    chk("a5_data",  32'(data_p),  32'h A5);
    chk("a5_valid", 32'(valid_p), 32'd1);
    chk("a5_perr",  32'(err_p),   32'd0);
    tick(1'b1, 1'b1);
    chk("a5_once",  32'(valid_p), 32'd0);

    // parity error still delivers the word
    frame_p(8'hA5, 1'b1);
    repeat (10) tick(1'b0, 1'b1);
    chk("perr_data", 32'(data_p), 32'hA5);
    chk("perr_flag", 32'(err_p),  32'd1);
    tick(1'b1, 1'b1);
    chk("perr_drop", 32'(valid_p), 32'd0);

    // back-to-back with downstream stalled
    frame_p(8'h3C, 1'b0);
    frame_p(8'hFF, 1'b0);
    repeat (20) tick(1'b0, 1'b1);
    chk("ovr_pulse", 32'(ovr_p),   32'd1);
    chk("ovr_hold",  32'(data_p),  32'h3C);
    chk("ovr_valid", 32'(valid_p), 32'd1);
    tick(1'b0, 1'b1);
    chk("ovr_once",  32'(ovr_p),   32'd0);
    tick(1'b1, 1'b1);
    chk("hold_rel",  32'(valid_p), 32'd0);

    // consume and load on the same edge
    frame_p(8'h3C, 1'b0);
    frame_p(8'h81, 1'b0);
    repeat (19) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    chk("swap_valid", 32'(valid_p), 32'd1);
    chk("swap_data",  32'(data_p),  32'h81);
    chk("swap_ovr",   32'(ovr_p),   32'd0);
    tick(1'b1, 1'b1);

    // reset mid-frame
    qp.push_back(1'b1); qp.push_back(1'b1); qp.push_back(1'b0);
    qp.push_back(1'b1); qp.push_back(1'b0);
    repeat (5) tick(1'b0, 1'b1);
    chk("mid_busy", 32'(busy_p), 32'd1);
    tick(1'b0, 1'b0);
    chk("rst_mid_busy",  32'(busy_p),  32'd0);
    chk("rst_mid_valid", 32'(valid_p), 32'd0);
    repeat (12) tick(1'b0, 1'b1);
    chk("rst_no_word", 32'(valid_p), 32'd0);
    frame_p(8'h5A, 1'b0);
    repeat (10) tick(1'b0, 1'b1);
    chk("post_rst_data",  32'(data_p),  32'h5A);
    chk("post_rst_valid", 32'(valid_p), 32'd1);
    tick(1'b1, 1'b1);

    // no-parity build
    frame_n(8'h0F);
    repeat (9) tick(1'b1, 1'b1);
    chk("nop_data",  32'(data_n),  32'h0F);
    chk("nop_valid", 32'(valid_n), 32'd1);
    chk("nop_perr",  32'(err_n),   32'd0);
    tick(1'b1, 1'b1);

    // random line traffic, random backpressure, rare resets
    repeat (3000) begin
      if (qp.size() == 0) qp.push_back(1'($urandom_range(0, 1)));
      if (qn.size() == 0) qn.push_back(1'($urandom_range(0, 1)));
      tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 299) != 0));
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
